// File: rtl/snake_pkg.sv
// Shared snake-game constants and types.
// Grid geometry and the collision FSM encoding live here so neighbouring blocks agree.
package snake_pkg;
    localparam int COORD_W = 5;
    localparam int GRID_W  = 20;
    localparam int GRID_H  = 15;
    localparam int MAX_LEN = 50;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} coll_state_t;
endpackage

// File: rtl/collision_checker.sv
// Classifies each new head position as apple eaten, fatal (wall/self) or neutral.
// Self-hits are found by serially scanning an external body memory with a 1-cycle read port.
module collision_checker #(
    parameter int COORD_W = snake_pkg::COORD_W,
    parameter int GRID_W  = snake_pkg::GRID_W,
    parameter int GRID_H  = snake_pkg::GRID_H,
    parameter int MAX_LEN = snake_pkg::MAX_LEN,
    localparam int AW     = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move_tick,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic [COORD_W-1:0] apple_x,
    input  logic [COORD_W-1:0] apple_y,
    input  logic [6:0]         snake_len,
    output logic [AW-1:0]      body_rd_addr,
    input  logic [COORD_W-1:0] body_x,
    input  logic [COORD_W-1:0] body_y,
    output logic               goodColl,
    output logic               badColl,
    output logic               check_done,
    output logic               busy
);
    import snake_pkg::*;

    coll_state_t        r_state;
    logic [COORD_W-1:0] r_head_x, r_head_y;
    logic [COORD_W-1:0] r_apple_x, r_apple_y;
    logic [6:0]         r_len;
    logic               r_apple_hit;
    logic [AW-1:0]      r_addr;
    logic [6:0]         r_cmp_idx;
    logic               r_first;
    logic               r_good, r_bad, r_done, r_busy;

    logic [6:0] w_len_clamp;
    logic [6:0] w_addr_ext;
    logic       w_wall_hit;
    logic       w_seg_hit;
    logic       w_more_addr;

    assign w_len_clamp = (32'(snake_len) > MAX_LEN) ? 7'(MAX_LEN) : snake_len;
    assign w_addr_ext  = 7'(r_addr);
    assign w_wall_hit  = (32'(r_head_x) >= GRID_W) || (32'(r_head_y) >= GRID_H);
    assign w_seg_hit   = (body_x == r_head_x) && (body_y == r_head_y);
    assign w_more_addr = w_addr_ext < (r_len - 7'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_head_x    <= '0;
            r_head_y    <= '0;
            r_apple_x   <= '0;
            r_apple_y   <= '0;
            r_len       <= '0;
            r_apple_hit <= 1'b0;
            r_addr      <= '0;
            r_cmp_idx   <= '0;
            r_first     <= 1'b0;
            r_good      <= 1'b0;
            r_bad       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_good <= 1'b0;
            r_bad  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (move_tick) begin
                    r_head_x    <= head_x;
                    r_head_y    <= head_y;
                    r_apple_x   <= apple_x;
                    r_apple_y   <= apple_y;
                    r_len       <= w_len_clamp;
                    r_apple_hit <= (head_x == apple_x) && (head_y == apple_y);
                    r_busy      <= 1'b1;
                    r_state     <= CHECK;
                end
                CHECK: begin
                    if (w_wall_hit) begin
                        r_bad   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_len == '0) begin
                        r_good  <= r_apple_hit;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_addr    <= '0;
                        r_cmp_idx <= '0;
                        r_first   <= 1'b1;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    // Read data lags the address by a cycle, so the first SCAN cycle has nothing to compare.
                    if (r_first) begin
                        r_first <= 1'b0;
                        if (w_more_addr) r_addr <= r_addr + 1'b1;
                    end else if (w_seg_hit) begin
                        r_bad   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_cmp_idx == r_len - 7'd1) begin
                        r_good  <= r_apple_hit;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cmp_idx <= r_cmp_idx + 7'd1;
                        if (w_more_addr) r_addr <= r_addr + 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign body_rd_addr = r_addr;
    assign goodColl     = r_good;
    assign badColl      = r_bad;
    assign check_done   = r_done;
    assign busy         = r_busy;
endmodule

// File: tb/tb_collision_checker.sv
// Randomised self-checking bench for collision_checker against an outcome/latency model.
// The model derives verdict and DONE cycle straight from the game rules, not the FSM.
module tb_collision_checker;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       move_tick = 1'b0;
    logic [4:0] head_x = '0, head_y = '0, apple_x = '0, apple_y = '0;
    logic [6:0] snake_len = '0;
    logic [5:0] body_rd_addr;
    logic [4:0] body_x, body_y;
    logic       goodColl, badColl, check_done, busy;

    logic [4:0] mem_x [64];
    logic [4:0] mem_y [64];

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External body memory with a 1-cycle synchronous read.
    always @(posedge clk) begin
        body_x <= mem_x[body_rd_addr];
        body_y <= mem_y[body_rd_addr];
    end

    collision_checker dut (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .head_x(head_x), .head_y(head_y), .apple_x(apple_x), .apple_y(apple_y),
        .snake_len(snake_len), .body_rd_addr(body_rd_addr),
        .body_x(body_x), .body_y(body_y),
        .goodColl(goodColl), .badColl(badColl), .check_done(check_done), .busy(busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_mem_far();
        for (int i = 0; i < 64; i++) begin
            mem_x[i] = 5'd31;
            mem_y[i] = 5'd31;
        end
    endtask

    // Expected DONE cycle (relative to the move_tick cycle), verdict, and last
    // segment index whose address must appear on the bus (-1: no reads).
    task automatic model(input int hx, hy, ax, ay, len,
                         output int lat, good, bad, last);
        int n, k;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        k = -1;
        if (hx >= GRID_W || hy >= GRID_H) begin
            lat = 2; bad = 1; good = 0; last = -1;
        end else if (n == 0) begin
            lat = 2; bad = 0; good = (hx == ax && hy == ay); last = -1;
        end else begin
            for (int i = 0; i < n; i++)
                if (k < 0 && mem_x[i] == hx && mem_y[i] == hy) k = i;
            if (k >= 0) begin
                lat = k + 4; bad = 1; good = 0; last = k;
            end else begin
                lat = n + 3; bad = 0; good = (hx == ax && hy == ay); last = n - 1;
            end
        end
    endtask

    task automatic run(input string tag, input int hx, hy, ax, ay, len, input bit extra);
        int lat, good, bad, last;
        int done_n, goodv, badv, spur, addr_bad, busy_bad;
        logic [5:0] addr_before;
        model(hx, hy, ax, ay, len, lat, good, bad, last);
        done_n = 0; goodv = 0; badv = 0; spur = 0; addr_bad = 0; busy_bad = 0;
        @(negedge clk);
        addr_before = body_rd_addr;
        head_x = 5'(hx); head_y = 5'(hy); apple_x = 5'(ax); apple_y = 5'(ay);
        snake_len = 7'(len);
        move_tick = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 80 && done_n == 0; n++) begin
            @(negedge clk);
            move_tick = 1'b0;
            if (!busy) busy_bad++;
            if (n >= 2 && n <= last + 2 && int'(body_rd_addr) != n - 2) addr_bad++;
            if (check_done) begin
                done_n = n; goodv = goodColl; badv = badColl;
            end else begin
                if (goodColl || badColl) spur++;
                if (extra && (n % 3 == 0)) begin
                    move_tick = 1'b1;
                    head_x = 5'($urandom_range(0, 31));
                    snake_len = 7'($urandom_range(0, 127));
                end
            end
        end
        chk({tag, ".lat"}, done_n, lat);
        chk({tag, ".good"}, goodv, good);
        chk({tag, ".bad"}, badv, bad);
        chk({tag, ".spur"}, spur, 0);
        chk({tag, ".busy"}, busy_bad, 0);
        chk({tag, ".addr"}, addr_bad, 0);
        if (last < 0) chk({tag, ".noread"}, int'(body_rd_addr), int'(addr_before));
        @(negedge clk);
        move_tick = 1'b0;
        chk({tag, ".idle"}, {busy, check_done, goodColl, badColl}, 0);
    endtask

    initial begin
        int hx, hy, ax, ay, len, k;
        fill_mem_far();
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst.out", {goodColl, badColl, check_done, busy}, 0);
        chk("rst.addr", int'(body_rd_addr), 0);
        rst = 1'b0;

        run("apple", 3, 4, 3, 4, 5, 1'b0);
        run("wall", 20, 2, 20, 2, 5, 1'b0);
        run("wall_y", 2, 15, 9, 9, 5, 1'b0);
        mem_x[2] = 5'd7; mem_y[2] = 5'd7;
        run("self2", 7, 7, 1, 1, 6, 1'b0);
        fill_mem_far();
        mem_x[0] = 5'd1; mem_y[0] = 5'd1;
        run("self0", 1, 1, 1, 1, 6, 1'b0);
        fill_mem_far();
        run("clamp", 5, 5, 6, 6, 60, 1'b1);
        run("len0", 4, 4, 4, 4, 0, 1'b0);
        run("len1", 19, 14, 0, 0, 1, 1'b0);

        // Reset during a len-10 scan: outputs clear at once and nothing fires.
        @(negedge clk);
        head_x = 5'd2; head_y = 5'd2; apple_x = 5'd2; apple_y = 5'd2;
        snake_len = 7'd10; move_tick = 1'b1;
        @(posedge clk);
        @(negedge clk); move_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.out", {goodColl, badColl, check_done, busy}, 0);
        chk("midrst.addr", int'(body_rd_addr), 0);
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (goodColl || badColl || check_done || busy) k++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (goodColl || badColl || check_done || busy) k++;
        end
        chk("midrst.quiet", k, 0);
        run("after_rst", 2, 2, 2, 2, 10, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 64; i++) begin
                mem_x[i] = 5'($urandom_range(0, 31));
                mem_y[i] = 5'($urandom_range(0, 31));
            end
            hx = $urandom_range(0, 23);
            hy = $urandom_range(0, 17);
            len = $urandom_range(0, 70);
            if ($urandom_range(0, 1) == 1) begin
                ax = hx; ay = hy;
            end else begin
                ax = $urandom_range(0, 19); ay = $urandom_range(0, 14);
            end
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 55);
                mem_x[k] = 5'(hx); mem_y[k] = 5'(hy);
            end
            run($sformatf("rnd%0d", t), hx, hy, ax, ay, len, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
